// File: rtl/mux_rr_pkg.sv
// Shared definitions for the registered select/round-robin mux.
//   MODE_FIXED / MODE_RR : values of the mux_rr_reg `mode` input.
//   onehot_to_idx        : index of the set bit in a one-hot vector. Pass the
//                          vector zero-extended to 64 bits. An all-zero vector
//                          returns 0.
package mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic logic [31:0] onehot_to_idx(input logic [63:0] vec);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (vec[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_reg_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
// The search starts at channel ptr+1 and wraps modulo N. It grants the first
// requesting channel it finds, so the channel that was granted last
// (recorded in ptr) gets the lowest priority.
// Ports:
//   req : per-channel requests
//   ptr : index of the channel granted most recently
//   gnt : one-hot grant, all zero when nothing requests
//   any : at least one request is present
module rr_pick
  import mux_rr_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic          found;
  logic [SW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = SW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-channel, W-bit mux with one registered output slot and a
// valid/ready handshake on every channel and on the output.
//   mode=0 : fixed select. The channel comes from sel. If sel >= N, no
//            channel is granted.
//   mode=1 : round-robin among the channels that assert valid.
// Optional build macro: MUX_RR_REG_PARITY_EN. It adds the in_par, out_par
// and par_err ports.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   mode, sel         : arbitration mode and fixed-mode channel index
//   in_data/in_valid  : flattened channel data (ch i at [i*W +: W]) and valids
//   in_ready          : per-channel ready, at most one bit set
//   out_data/out_ch   : registered beat and the channel that supplied it
//   out_valid/out_ready : output handshake
//   in_par            : per-channel even parity (parity build only)
//   out_par           : ^out_data, registered with out_data (parity build only)
//   par_err           : sticky flag for an input parity mismatch (parity build only)
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. Once valid is high, it stays high until that edge.
// Ready may depend on valid. Valid must never depend on ready.
module mux_rr_reg
  import mux_rr_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 16,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
`ifdef MUX_RR_REG_PARITY_EN
  ,
  input  logic [N-1:0]    in_par,
  output logic            out_par,
  output logic            par_err
`endif
);

  logic [SW-1:0] ptr;
  logic          accept;
  logic [N-1:0]  gnt_fix;
  logic [N-1:0]  gnt_rr;
  logic          rr_any;
  logic [N-1:0]  grant;
  logic          xfer;
  logic [SW-1:0] xfer_idx;
  logic [W-1:0]  xfer_data;

  // The slot can load when it is empty or when its beat drains on this edge.
  // Draining and filling in the same edge keeps full throughput.
  assign accept = !out_valid || out_ready;

  always_comb begin
    gnt_fix = '0;
    // sel can exceed N-1 only when N is not a power of two.
    if (int'(sel) < N) gnt_fix[sel] = in_valid[sel];
  end

  rr_pick #(.N(N)) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .gnt (gnt_rr),
    .any (rr_any)
  );

  always_comb begin
    grant = '0;
    if (mode == MODE_RR) begin
      if (rr_any) grant = gnt_rr;
    end else begin
      grant = gnt_fix;
    end
  end

  // Gating with rst_n keeps every ready low while reset is held.
  assign in_ready  = grant & {N{accept}} & {N{rst_n}};
  assign xfer      = |in_ready;
  assign xfer_idx  = SW'(onehot_to_idx(64'(grant)));
  assign xfer_data = in_data[int'(xfer_idx)*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= xfer_data;
      out_ch    <= xfer_idx;
      ptr       <= xfer_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_RR_REG_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par <= 1'b0;
      par_err <= 1'b0;
    end else if (xfer) begin
      out_par <= ^xfer_data;
      if ((^xfer_data) != in_par[xfer_idx]) par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// Self-checking bench for mux_rr_reg with N=8 and W=16.
// A behavioural model computes the expected grant, the output register
// contents, the pointer and the parity state from the arbitration rules.
// The bench compares the DUT against that model on every falling edge.
// Directed sections pin the model with literal values. Inputs change 1
// time unit after the rising edge.
module tb_mux_rr_reg;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;
`ifdef MUX_RR_REG_PARITY_EN
  logic [N-1:0]    in_par;
  logic            out_par;
  logic            par_err;
`endif

  always #5 clk = ~clk;

  mux_rr_reg #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_RR_REG_PARITY_EN
    ,
    .in_par    (in_par),
    .out_par   (out_par),
    .par_err   (par_err)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_valid = 1'b0;
  logic [W-1:0]  m_data  = '0;
  int            m_ch    = 0;
  int            m_ptr   = N - 1;
  bit            m_par   = 1'b0;
  bit            m_perr  = 1'b0;
  logic [SW+W-1:0] exp_q[$];
  logic [SW-1:0]   ch_log[$];

  // Returns the channel that moves on the coming edge, or -1 for none.
  function automatic int model_pick();
    int c;
    if (m_valid && !out_ready) return -1;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit model_par_bad(input int g);
`ifdef MUX_RR_REG_PARITY_EN
    return (^in_data[g*W +: W]) != in_par[g];
`else
    return (g < 0);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_ptr   = N - 1;
      m_par   = 1'b0;
      m_perr  = 1'b0;
      exp_q.delete();
    end else begin
      g = model_pick();
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_ch    = g;
        m_ptr   = g;
        m_par   = ^m_data;
        if (model_par_bad(g)) m_perr = 1'b1;
        exp_q.push_back({SW'(g), m_data});
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    logic [SW+W-1:0] beat;
    if (checking) begin
      exp_rdy = '0;
      if (rst_n) begin
        g = model_pick();
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_ch", 64'(out_ch), 64'(m_ch));
`ifdef MUX_RR_REG_PARITY_EN
      chk("out_par", 64'(out_par), 64'(m_par));
      chk("par_err", 64'(par_err), 64'(m_perr));
`endif
      if (rst_n && out_valid && out_ready) begin
        ch_log.push_back(out_ch);
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 64'({out_ch, out_data}), 64'(0));
        end else begin
          beat = exp_q.pop_front();
          chk("beat", 64'({out_ch, out_data}), 64'(beat));
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_good_par();
`ifdef MUX_RR_REG_PARITY_EN
    for (int i = 0; i < N; i++) in_par[i] = ^in_data[i*W +: W];
`endif
  endtask

  task automatic check_log(input string nm, input int exp_seq[]);
    chk({nm, "_len"}, 64'(ch_log.size()), 64'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < ch_log.size(); i++)
      chk(nm, 64'(ch_log[i]), 64'(exp_seq[i]));
  endtask

  initial begin
    mode      = 1'b1;
    sel       = '0;
    in_data   = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    set_good_par();
    #1 rst_n = 1'b0;
    cyc();
    checking = 1'b1;

    // Reset with every channel requesting.
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_ch", 64'(out_ch), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));

    // Release. Round-robin starts at channel 0.
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
    set_good_par();
    ch_log.delete();
    @(negedge clk);
    chk("first_grant", 64'(in_ready), 64'(8'h01));
    repeat (9) cyc();
    in_valid = 8'h81;
    repeat (4) cyc();
    in_valid = 8'h00;
    repeat (2) cyc();
    check_log("rr_seq", '{0, 1, 2, 3, 4, 5, 6, 7, 0, 7, 0, 7, 0});

    // Fixed select.
    mode = 1'b0;
    sel  = 3'd3;
    in_data[3*W +: W] = 16'hBEEF;
    in_valid = 8'h08;
    set_good_par();
    @(negedge clk);
    chk("fix_ready", 64'(in_ready), 64'(8'h08));
    cyc();
    sel = 3'd5;
    @(negedge clk);
    chk("fix_data", 64'(out_data), 64'(16'hBEEF));
    chk("fix_ch", 64'(out_ch), 64'(3));
    chk("fix_valid", 64'(out_valid), 64'(1));
    chk("fix_sel5_ready", 64'(in_ready), 64'(0));
    cyc();
    @(negedge clk);
    chk("fix_drain", 64'(out_valid), 64'(0));

    // Back-pressure with the ch2 beat held.
    cyc();
    sel = 3'd2;
    in_data[2*W +: W] = 16'h1234;
    in_valid  = 8'h04;
    out_ready = 1'b0;
    set_good_par();
    cyc();
    mode = 1'b1;
    in_valid = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_data", 64'(out_data), 64'(16'h1234));
      chk("bp_ch", 64'(out_ch), 64'(2));
      chk("bp_ready", 64'(in_ready), 64'(0));
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", 64'(in_ready), 64'(8'h08));
    cyc();
    @(negedge clk);
    chk("bp_next_ch", 64'(out_ch), 64'(3));

    // Switch from round-robin to fixed sel=6 while streaming.
    repeat (2) cyc();
    mode = 1'b0;
    sel  = 3'd6;
    ch_log.delete();
    repeat (5) cyc();
    check_log("switch_seq", '{5, 6, 6, 6, 6});

`ifdef MUX_RR_REG_PARITY_EN
    // Bad parity on channel 1.
    sel = 3'd1;
    in_valid = 8'h02;
    in_data[1*W +: W] = 16'h0001;
    set_good_par();
    in_par[1] = 1'b0;
    cyc();
    in_valid = 8'h00;
    set_good_par();
    @(negedge clk);
    chk("par_err_set", 64'(par_err), 64'(1));
    chk("par_out_par", 64'(out_par), 64'(1));
    repeat (3) cyc();
    @(negedge clk);
    chk("par_err_sticky", 64'(par_err), 64'(1));
`endif

    // Randomised traffic with occasional mid-beat resets.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) sel = SW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      set_good_par();
`ifdef MUX_RR_REG_PARITY_EN
      if ($urandom_range(0, 99) == 0) in_par = N'($urandom);
`endif
    end
    rst_n = 1'b1;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised successor to the datapath's fixed 8x16 select mux: N channels of W bits, one registered output, valid/ready handshake on every channel and on the output.
- Two modes:
  - Fixed select: channel chosen by `sel`.
  - Round-robin arbitration: fair among channels that are asserting valid.
- Sits between producer units (register file read ports, ALU, memory return) and a single shared consumer bus.
- Adds back-pressure and fairness, which the plain combinational mux lacks.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 16, data width per channel.
- SW is a localparam, not a parameter: SW = $clog2(N).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SW  channel index used in fixed mode.
- in_data  in  N*W  flattened inputs; channel i occupies [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit set.
- out_data  out  W  registered output data.
- out_ch  out  SW  index of the channel that supplied out_data.
- out_valid  out  1  out_data/out_ch hold a beat.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=N-1, so channel 0 has first priority.
  - in_ready=0 while rst_n low.
- Output slot:
  - accept = !out_valid || out_ready.
  - A beat leaves on out_valid && out_ready.
- Grant is one-hot, combinational from current inputs and state:
  - Fixed mode: grant[sel] = in_valid[sel]. If sel >= N (non-power-of-two N), no grant.
  - Round-robin mode: grant the first i with in_valid[i], searching ptr+1, ptr+2, ... modulo N, wrapping past N-1 to 0.
- in_ready = grant & {N{accept}}. in_ready may depend on in_valid; producers must not make in_valid depend on in_ready.
- Transfer on channel i when in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= channel i data.
  - out_ch <= i.
  - out_valid <= 1.
  - ptr <= i. ptr updates on every transfer, in either mode.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_ch hold their last values.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one beat per cycle while out_ready is held high. No bubble on simultaneous drain and fill.
- Stall: out_valid=1 and out_ready=0 means accept=0 and all in_ready=0. out_data, out_ch and ptr are frozen.
- Mode or sel change: takes effect on the next grant decision. A beat already in the output register is unaffected.
- No valid inputs: no grant, ptr unchanged.
- Reset mid-beat: the held beat is discarded and out_valid drops immediately.

Optional Feature:
- Macro: MUX_RR_REG_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit) = ^out_data, registered in the same edge as out_data; reset value 0.
  - Adds input port in_par (N bits) carrying per-channel even parity.
  - Adds sticky output par_err (1 bit): set on any transfer where ^in_data[i] != in_par[i], cleared only by reset.
- When undefined: these ports and the logic behind them do not exist. Behaviour is otherwise identical.

Decomposition:
- Package mux_rr_pkg:
  - Constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - A function that returns the index of a one-hot vector.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Parameter N; inputs req[N], ptr[SW]; outputs gnt[N], any.
  - Reused by mux_rr_reg in round-robin mode.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. Release, mode=RR, out_ready=1 -> first beat has out_ch=0.
- Fixed mode, N=8, W=16: sel=3, in_data ch3=16'hBEEF, in_valid=8'h08 -> in_ready=8'h08; next cycle out_data=16'hBEEF, out_ch=3, out_valid=1. Then sel=5 with in_valid[5]=0 -> in_ready=0, and out_valid drops after the drain.
- RR fairness: in_valid=8'hFF held, out_ready=1 -> out_ch sequence 0,1,2,...,7,0 with one beat per cycle. Then in_valid=8'h81 -> sequence 7,0,7,0.
- Back-pressure: out_ready=0 for 4 cycles with beat ch2=16'h1234 held -> out_data stable, in_ready=0, ptr unchanged. Release -> next grant is channel 3 if valid.
- Mid-stream mode switch: RR streaming, switch to fixed with sel=6 -> the held beat is delivered unchanged, then only channel 6 is granted.
- MUX_RR_REG_PARITY_EN build: ch1 data 16'h0001 with in_par[1]=0 -> par_err=1 after the transfer, staying 1 until reset; out_par=1 for that beat.
